// File: rtl/shift_unit_iter_if.sv
// Request/response bundle for the iterative shifter.
// The master drives the request fields; the slave returns the result and status.
interface shift_unit_iter_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    logic [1:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;

    modport master (
        output start, op, shamt, in_data,
        input  out_data, busy, done
    );

    modport slave (
        input  start, op, shamt, in_data,
        output out_data, busy, done
    );
endinterface

// File: rtl/shift_unit_iter.sv
// Multi-cycle SLL/SRL/SRA shifter, moving up to STEP bit positions per clock.
// Define SHIFT_ROTATE_EN to add rotate-right on op=11; otherwise op=11 acts as SLL.
module shift_unit_iter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    shift_unit_iter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] STEP_N = SHW'(STEP);

    typedef enum logic {S_IDLE, S_BUSY} state_e;
    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   rem_q, rem_d;
    op_e              op_q, op_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             done_q, done_d;

    logic [SHW-1:0]   n;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] shifted;

`ifdef SHIFT_ROTATE_EN
    localparam logic [SHW:0] WIDTH_N = (SHW+1)'(WIDTH);
    logic [SHW:0] rot_amt;
    assign rot_amt = WIDTH_N - {1'b0, n};
`endif

    // One step of the captured operation; the final step takes only what is left.
    always_comb begin
        n       = (rem_q < STEP_N) ? rem_q : STEP_N;
        fill    = ~({WIDTH{1'b1}} >> n);
        shifted = work_q << n;
        case (op_q)
            OP_SRL:  shifted = work_q >> n;
            OP_SRA:  shifted = (work_q >> n) | (sign_q ? fill : '0);
`ifdef SHIFT_ROTATE_EN
            OP_ROTR: shifted = (work_q >> n) | (work_q << rot_amt);
`endif
            default: shifted = work_q << n;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    work_d  = bus.in_data;
                    rem_d   = bus.shamt;
                    op_d    = op_e'(bus.op);
                    sign_d  = bus.in_data[WIDTH-1];
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (rem_q == '0) begin
                    out_d   = work_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    work_d = shifted;
                    rem_d  = rem_q - n;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            op_q    <= OP_SLL;
            sign_q  <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign bus.out_data = out_q;
    assign bus.busy     = (state_q == S_BUSY);
    assign bus.done     = done_q;
endmodule
